// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator sharing one frame counter.
// Targets are written any time; active positions (optionally slewed) load at frame wrap.
module servo_pwm_multi #(
   parameter int CHANNELS  = 4,
   parameter int POS_W     = 8,
   parameter int FRAME_CYC = 1000000,
   parameter int MIN_CYC   = 50000,
   parameter int STEP_CYC  = 196,
   parameter int SLEW      = 0,
   localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [CHW-1:0]            wr_ch,
   input  logic [POS_W-1:0]          wr_pos,
   input  logic [CHANNELS-1:0]       ch_enable,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic                      frame_start,
   output logic [CHANNELS*POS_W-1:0] cur_pos
);

   localparam int CW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
   localparam int WW = CW + POS_W;
   localparam longint MAX_W = longint'(MIN_CYC)
      + ((longint'(1) << POS_W) - 1) * longint'(STEP_CYC);
   localparam logic [POS_W-1:0] CENTER = POS_W'(1) << (POS_W - 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_CYC - 1);

   typedef logic [WW-1:0] w_t;

   generate
      if (MAX_W >= longint'(FRAME_CYC)) begin : g_bad_cfg
         $error("servo_pwm_multi: widest pulse does not fit in frame");
      end
   endgenerate

   logic [CW-1:0]       cnt_q, cnt_d;
   logic                run_q, run_d;
   logic                wrap;
   logic [POS_W-1:0]    target_q [CHANNELS];
   logic [POS_W-1:0]    target_d [CHANNELS];
   logic [POS_W-1:0]    active_q [CHANNELS];
   logic [POS_W-1:0]    active_d [CHANNELS];
   logic [CHANNELS-1:0] en_q, en_d;
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic                fs_q, fs_d;

   function automatic logic [POS_W-1:0] slew_step(
      input logic [POS_W-1:0] act,
      input logic [POS_W-1:0] tgt
   );
      logic [POS_W-1:0] diff;
      diff = (tgt > act) ? tgt - act : act - tgt;
      if (SLEW == 0 || int'(diff) <= SLEW) return tgt;
      if (tgt > act) return act + POS_W'(SLEW);
      return act - POS_W'(SLEW);
   endfunction

   function automatic w_t pulse_w(input logic [POS_W-1:0] pos);
      return w_t'(MIN_CYC) + w_t'(pos) * w_t'(STEP_CYC);
   endfunction

   // run_q low means the next edge is the first after reset: treat it as a wrap
   always_comb begin
      wrap  = !run_q || (cnt_q == LAST);
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      run_d = 1'b1;
      fs_d  = wrap;
      en_d  = wrap ? ch_enable : en_q;
      target_d = target_q;
      if (wr_en && (32'(wr_ch) < CHANNELS)) begin
         target_d[wr_ch] = wr_pos;
      end
      pwm_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         active_d[i] = wrap ? slew_step(active_q[i], target_q[i])
                            : active_q[i];
         pwm_d[i] = en_d[i] && (w_t'(cnt_d) < pulse_w(active_d[i]));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         run_q <= 1'b0;
         fs_q  <= 1'b0;
         en_q  <= '0;
         pwm_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            target_q[i] <= CENTER;
            active_q[i] <= CENTER;
         end
      end else begin
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         fs_q     <= fs_d;
         en_q     <= en_d;
         pwm_q    <= pwm_d;
         target_q <= target_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      cur_pos = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cur_pos[i*POS_W +: POS_W] = active_q[i];
      end
   end

   assign pwm_out     = pwm_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Frame-level bench for servo_pwm_multi: SLEW=0, SLEW=3 and a 3-channel
// instance share clock, reset and enables; each frame is checked per cycle.
module tb_servo_pwm_multi;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [0:0]  wr_ch;
   logic        wr_en_c;
   logic [1:0]  wr_ch_c;
   logic [3:0]  wr_pos;
   logic [1:0]  ch_enable;
   logic [1:0]  pwm_a, pwm_s;
   logic [2:0]  pwm_c;
   logic        fs_a, fs_s, fs_c;
   logic [7:0]  pos_a, pos_s;
   logic [11:0] pos_c;

   int checks = 0;
   int errors = 0;

   servo_pwm_multi #(
      .CHANNELS(2), .POS_W(4), .FRAME_CYC(100),
      .MIN_CYC(10), .STEP_CYC(2), .SLEW(0)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_pos(wr_pos), .ch_enable(ch_enable), .pwm_out(pwm_a),
      .frame_start(fs_a), .cur_pos(pos_a)
   );

   servo_pwm_multi #(
      .CHANNELS(2), .POS_W(4), .FRAME_CYC(100),
      .MIN_CYC(10), .STEP_CYC(2), .SLEW(3)
   ) u_dut_s (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_pos(wr_pos), .ch_enable(ch_enable), .pwm_out(pwm_s),
      .frame_start(fs_s), .cur_pos(pos_s)
   );

   servo_pwm_multi #(
      .CHANNELS(3), .POS_W(4), .FRAME_CYC(100),
      .MIN_CYC(10), .STEP_CYC(2), .SLEW(0)
   ) u_dut_c (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en_c), .wr_ch(wr_ch_c),
      .wr_pos(wr_pos), .ch_enable({1'b1, ch_enable}), .pwm_out(pwm_c),
      .frame_start(fs_c), .cur_pos(pos_c)
   );

   typedef struct {
      int wk1; int wch1; int wpos1;
      int wk2; int wch2; int wpos2;
      int ek;  logic [1:0] en;
      int ck;  int cch;  int cpos;
      int aw0; int aw1; int ap0; int ap1;
      int sw0; int sw1; int sp0; int sp1;
      int cexp;
   } frame_t;

   frame_t tab [11];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   // Entered on the negedge of the frame_start cycle; leaves on the next one.
   task automatic run_frame(input frame_t f, input int idx);
      int c0, c1, s0, s1, bad_shape, bad_fs;
      c0 = 0; c1 = 0; s0 = 0; s1 = 0; bad_shape = 0; bad_fs = 0;
      for (int k = 0; k < 100; k++) begin
         wr_en   = 1'b0;
         wr_en_c = 1'b0;
         if (k == 0 || k == 99) begin
            chk($sformatf("f%0d k%0d pos_a", idx, k),
                int'(pos_a), f.ap1 * 16 + f.ap0);
            chk($sformatf("f%0d k%0d pos_s", idx, k),
                int'(pos_s), f.sp1 * 16 + f.sp0);
            if (f.cexp >= 0)
               chk($sformatf("f%0d k%0d pos_c", idx, k),
                   int'(pos_c), f.cexp);
         end
         if (fs_a != (k == 0) || fs_s != (k == 0) || fs_c != (k == 0))
            bad_fs++;
         if (pwm_a[0] != (k < f.aw0) || pwm_a[1] != (k < f.aw1))
            bad_shape++;
         if (pwm_s[0] != (k < f.sw0) || pwm_s[1] != (k < f.sw1))
            bad_shape++;
         c0 += int'(pwm_a[0]);
         c1 += int'(pwm_a[1]);
         s0 += int'(pwm_s[0]);
         s1 += int'(pwm_s[1]);
         if (k == f.wk1) begin
            wr_en = 1'b1; wr_ch = 1'(f.wch1); wr_pos = 4'(f.wpos1);
         end
         if (k == f.wk2) begin
            wr_en = 1'b1; wr_ch = 1'(f.wch2); wr_pos = 4'(f.wpos2);
         end
         if (k == f.ck) begin
            wr_en_c = 1'b1; wr_ch_c = 2'(f.cch); wr_pos = 4'(f.cpos);
         end
         if (k == f.ek) ch_enable = f.en;
         @(negedge clk);
      end
      chk($sformatf("f%0d width a0", idx), c0, f.aw0);
      chk($sformatf("f%0d width a1", idx), c1, f.aw1);
      chk($sformatf("f%0d width s0", idx), s0, f.sw0);
      chk($sformatf("f%0d width s1", idx), s1, f.sw1);
      chk($sformatf("f%0d pulse shape", idx), bad_shape, 0);
      chk($sformatf("f%0d frame_start", idx), bad_fs, 0);
   endtask

   initial begin
      tab[0]  = '{50,0,15, -1,0,0, -1,2'b11, -1,0,0,
                  26,26,8,8, 26,26,8,8, -1};
      tab[1]  = '{-1,0,0, -1,0,0, 5,2'b01, -1,0,0,
                  40,26,15,8, 32,26,11,8, -1};
      tab[2]  = '{99,0,0, -1,0,0, -1,2'b01, -1,0,0,
                  40,0,15,8, 38,0,14,8, -1};
      tab[3]  = '{-1,0,0, -1,0,0, 60,2'b11, -1,0,0,
                  40,0,15,8, 40,0,15,8, -1};
      tab[4]  = '{20,1,3, 70,1,12, -1,2'b11, -1,0,0,
                  10,26,0,8, 34,26,12,8, -1};
      tab[5]  = '{-1,0,0, -1,0,0, -1,2'b11, -1,0,0,
                  10,34,0,12, 28,32,9,11, -1};
      tab[6]  = '{50,0,0, -1,0,0, -1,2'b11, -1,0,0,
                  26,26,8,8, 26,26,8,8, 'h888};
      tab[7]  = '{-1,0,0, -1,0,0, -1,2'b11, 10,3,1,
                  10,26,0,8, 20,26,5,8, 'h888};
      tab[8]  = '{-1,0,0, -1,0,0, -1,2'b11, 10,2,15,
                  10,26,0,8, 14,26,2,8, 'h888};
      tab[9]  = '{-1,0,0, -1,0,0, -1,2'b11, -1,0,0,
                  10,26,0,8, 10,26,0,8, 'hF88};
      tab[10] = tab[9];

      rst_n = 1'b0; wr_en = 1'b0; wr_en_c = 1'b0;
      wr_ch = '0; wr_ch_c = '0; wr_pos = '0; ch_enable = 2'b11;
      repeat (3) @(negedge clk);
      chk("reset pwm_a", int'(pwm_a), 0);
      chk("reset pwm_c", int'(pwm_c), 0);
      chk("reset fs_a", int'(fs_a), 0);
      chk("reset pos_a", int'(pos_a), 'h88);
      chk("reset pos_s", int'(pos_s), 'h88);
      chk("reset pos_c", int'(pos_c), 'h888);

      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) run_frame(tab[i], i);

      repeat (12) @(negedge clk);
      chk("pre-reset pwm_a", int'(pwm_a), 2);
      chk("pre-reset pwm_s", int'(pwm_s), 3);
      rst_n = 1'b0;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         chk($sformatf("mid reset %0d pwm_a", r), int'(pwm_a), 0);
         chk($sformatf("mid reset %0d pwm_s", r), int'(pwm_s), 0);
         chk($sformatf("mid reset %0d fs_a", r), int'(fs_a), 0);
         chk($sformatf("mid reset %0d pos_a", r), int'(pos_a), 'h88);
         chk($sformatf("mid reset %0d pos_s", r), int'(pos_s), 'h88);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 6; i < 11; i++) run_frame(tab[i], i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
